// File: rtl/sram_mem_responder_pkg.sv
// sram_mem_responder_pkg: shared state encoding and constants for the SRAM data-memory responder.
package sram_mem_responder_pkg;
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
    localparam int ADDR_BASE_DEF = 1024;
    localparam int SRAM_DW = 16;
endpackage

// File: rtl/sram_mem_responder_timer.sv
// phase_timer: down-counter that marks the last cycle of a WAIT_CYCLES-long SRAM phase.
module phase_timer #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic last_o
);
    localparam int CW = $clog2(WAIT_CYCLES);
    logic [CW-1:0] cnt_q, cnt_d;
    assign last_o = cnt_q == '0;
    assign cnt_d = load_i ? CW'(WAIT_CYCLES - 1) : last_o ? cnt_q : cnt_q - CW'(1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/sram_mem_responder.sv
// sram_mem_responder: runs one 32-bit MEM read/write as two 16-bit phases on an async SRAM.
module sram_mem_responder
    import sram_mem_responder_pkg::*;
#(
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_BASE   = ADDR_BASE_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_en,
    input  logic                wr_en,
    input  logic [31:0]         addr,
    input  logic [31:0]         wr_data,
    output logic [31:0]         rd_data,
    output logic                ready,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic                sram_we_n,
    output logic [SRAM_DW-1:0]  sram_dq_out,
    output logic                sram_dq_oe,
    input  logic [SRAM_DW-1:0]  sram_dq_in
);
    state_t              state_q, state_d;
    logic                wr_q, wr_d;
    logic [31:0]         wd_q, wd_d;
    logic [31:0]         rd_q, rd_d;
    logic [SRAM_DW-1:0]  lo_q, lo_d;
    logic [SRAM_AW-1:0]  sa_q, sa_d;
    logic [SRAM_AW-2:0]  word;
    logic                go, load, last, phase;

    phase_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .last_o (last)
    );

    assign go    = rd_en | wr_en;
    assign word  = (SRAM_AW-1)'((addr - 32'(ADDR_BASE)) >> 2);
    assign phase = (state_q == LO) || (state_q == HI);

    // The low read half is parked in lo_q so rd_data only changes once the whole word is in.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        lo_d    = lo_q;
        sa_d    = sa_q;
        load    = 1'b0;
        case (state_q)
            IDLE: if (go) begin
                state_d = LO;
                wr_d    = wr_en;
                wd_d    = wr_data;
                sa_d    = {word, 1'b0};
                load    = 1'b1;
            end
            LO: if (last) begin
                state_d = HI;
                sa_d    = {sa_q[SRAM_AW-1:1], 1'b1};
                load    = 1'b1;
                if (!wr_q) lo_d = sram_dq_in;
            end
            HI: if (last) begin
                state_d = DONE;
                if (!wr_q) rd_d = {sram_dq_in, lo_q};
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            wd_q    <= '0;
            rd_q    <= '0;
            lo_q    <= '0;
            sa_q    <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            lo_q    <= lo_d;
            sa_q    <= sa_d;
        end
    end

    // Strobes decode straight from state so an async reset drops them instantly.
    assign ready       = ((state_q == IDLE) && !go) || (state_q == DONE);
    assign rd_data     = rd_q;
    assign sram_addr   = sa_q;
    assign sram_dq_oe  = wr_q && phase;
    assign sram_we_n   = !(wr_q && phase && !last);
    assign sram_dq_out = !sram_dq_oe ? '0 : (state_q == LO) ? wd_q[15:0] : wd_q[31:16];
endmodule

// File: tb/tb_sram_mem_responder.sv
// tb_sram_mem_responder: directed checks of the SRAM responder against a behavioural SRAM.
module tb_sram_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic [15:0] mem [16];
    logic        clear = 1'b0;
    int          checks = 0;
    int          errors = 0;

    sram_mem_responder #(.SRAM_AW(18), .WAIT_CYCLES(2), .ADDR_BASE(1024)) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .addr        (addr),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_we_n   (sram_we_n),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in)
    );

    always #5 clk = ~clk;

    assign sram_dq_in = mem[sram_addr[3:0]];

    always @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'h5A5A;
        end else if (!sram_we_n && sram_dq_oe) begin
            mem[sram_addr[3:0]] <= sram_dq_out;
        end
    end

    // Presents a request for one cycle and observes until ready rises (bounded at 20 cycles).
    task automatic do_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                         output int rlow, output int welow, output int pulses, output int oecyc);
        logic prev_we;
        rlow = 0; welow = 0; pulses = 0; oecyc = 0; prev_we = 1'b1;
        @(negedge clk);
        rd_en = rd; wr_en = wr; addr = a; wr_data = d;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (ready) break;
            rlow++;
            if (!sram_we_n) welow++;
            if (!sram_we_n && prev_we) pulses++;
            prev_we = sram_we_n;
            if (sram_dq_oe) oecyc++;
            @(negedge clk);
            rd_en = 1'b0; wr_en = 1'b0; addr = '1; wr_data = '0;
        end
    endtask

    task automatic test_reset();
        clear = 1'b1;
        repeat (2) @(negedge clk);
        clear = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
        checks++; if (sram_addr !== 18'h0) begin errors++; $display("FAIL reset_sram_addr: got %h expected 0", sram_addr); end
        checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n: got %b expected 1", sram_we_n); end
        checks++; if (sram_dq_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", sram_dq_oe); end
        checks++; if (sram_dq_out !== 16'h0) begin errors++; $display("FAIL reset_dq_out: got %h expected 0", sram_dq_out); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_write();
        int rl, wl, pu, oe;
        do_op(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, rl, wl, pu, oe);
        checks++; if (rl !== 5) begin errors++; $display("FAIL write_ready_low: got %0d expected 5", rl); end
        checks++; if (pu !== 2) begin errors++; $display("FAIL write_we_pulses: got %0d expected 2", pu); end
        checks++; if (wl !== 2) begin errors++; $display("FAIL write_we_low_cycles: got %0d expected 2", wl); end
        checks++; if (oe !== 4) begin errors++; $display("FAIL write_oe_cycles: got %0d expected 4", oe); end
        @(negedge clk);
        checks++; if (mem[0] !== 16'hBEEF) begin errors++; $display("FAIL write_mem0: got %h expected beef", mem[0]); end
        checks++; if (mem[1] !== 16'hDEAD) begin errors++; $display("FAIL write_mem1: got %h expected dead", mem[1]); end
    endtask

    task automatic test_read();
        int rl, wl, pu, oe;
        do_op(1'b1, 1'b0, 32'd1024, 32'h0, rl, wl, pu, oe);
        checks++; if (rl !== 5) begin errors++; $display("FAIL read_ready_low: got %0d expected 5", rl); end
        checks++; if (rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data: got %h expected deadbeef", rd_data); end
        checks++; if (oe !== 0) begin errors++; $display("FAIL read_oe_cycles: got %0d expected 0", oe); end
        checks++; if (wl !== 0) begin errors++; $display("FAIL read_we_low: got %0d expected 0", wl); end
        @(negedge clk);
    endtask

    task automatic test_addressing();
        int rl, wl, pu, oe;
        do_op(1'b0, 1'b1, 32'd1028, 32'h12345678, rl, wl, pu, oe);
        checks++; if (sram_addr !== 18'd3) begin errors++; $display("FAIL addr_done_sram_addr: got %0d expected 3", sram_addr); end
        @(negedge clk);
        checks++; if (mem[2] !== 16'h5678) begin errors++; $display("FAIL addr_mem2: got %h expected 5678", mem[2]); end
        checks++; if (mem[3] !== 16'h1234) begin errors++; $display("FAIL addr_mem3: got %h expected 1234", mem[3]); end
        checks++; if (mem[0] !== 16'hBEEF) begin errors++; $display("FAIL addr_mem0_kept: got %h expected beef", mem[0]); end
        checks++; if (mem[1] !== 16'hDEAD) begin errors++; $display("FAIL addr_mem1_kept: got %h expected dead", mem[1]); end
    endtask

    task automatic test_conflict();
        int rl, wl, pu, oe;
        do_op(1'b1, 1'b1, 32'd1032, 32'h0000A5A5, rl, wl, pu, oe);
        checks++; if (pu !== 2) begin errors++; $display("FAIL conflict_we_pulses: got %0d expected 2", pu); end
        checks++; if (rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL conflict_rd_data: got %h expected deadbeef", rd_data); end
        @(negedge clk);
        checks++; if (mem[4] !== 16'hA5A5) begin errors++; $display("FAIL conflict_mem4: got %h expected a5a5", mem[4]); end
        checks++; if (mem[5] !== 16'h0000) begin errors++; $display("FAIL conflict_mem5: got %h expected 0000", mem[5]); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        wr_en = 1'b1; addr = 32'd1040; wr_data = 32'hCAFEF00D;
        @(negedge clk);
        wr_en = 1'b0; addr = '1; wr_data = '0;
        #1;
        checks++; if (sram_we_n !== 1'b0) begin errors++; $display("FAIL areset_pre_we_n: got %b expected 0", sram_we_n); end
        checks++; if (sram_dq_oe !== 1'b1) begin errors++; $display("FAIL areset_pre_oe: got %b expected 1", sram_dq_oe); end
        #1 rst = 1'b0;
        #1;
        checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL areset_we_n: got %b expected 1", sram_we_n); end
        checks++; if (sram_dq_oe !== 1'b0) begin errors++; $display("FAIL areset_oe: got %b expected 0", sram_dq_oe); end
        checks++; if (sram_addr !== 18'h0) begin errors++; $display("FAIL areset_sram_addr: got %h expected 0", sram_addr); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL areset_ready_after: got %b expected 1", ready); end
        checks++; if (mem[8] !== 16'h5A5A) begin errors++; $display("FAIL areset_mem8: got %h expected 5a5a", mem[8]); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] got;
        got = '0;
        @(negedge clk);
        rd_en = 1'b1; addr = 32'd1024;
        for (int c = 0; c < 12; c++) begin
            #1 got[c] = ready;
            @(negedge clk);
        end
        rd_en = 1'b0; addr = '1;
        checks++; if (got !== 12'b1000_0010_0000) begin errors++; $display("FAIL b2b_ready_pattern: got %b expected 100000100000", got); end
        checks++; if (rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rd_data: got %h expected deadbeef", rd_data); end
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_ready: got %b expected 1", ready); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addressing();
        test_conflict();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
